// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : alu_sequencer
// Brief   : One-command-in-flight driver for the 16-bit ALU: strobes the op,
//           waits its latency, pushes the result and returns it on a response
//           handshake.
// Revision: 1.0 - initial release
// ============================================================================
module alu_sequencer #(
  parameter int DIV_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic [10:0] alu_op,
  output logic [3:0]  alu_push,
  output logic [15:0] bus1,
  output logic [15:0] bus2,
  input  logic [15:0] bus3,
  input  logic [15:0] bus4,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [3:0]  rsp_op,
  output logic        rsp_err
);

  localparam int             CNT_W    = (DIV_LATENCY < 2) ? 1 : $clog2(DIV_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 1);
  localparam logic [3:0]     OP_NOT   = 4'd10;
  localparam logic [3:0]     OP_DIV   = 4'd11;
  localparam logic [3:0]     OP_MOD   = 4'd12;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_WAIT = 3'd2,
    S_READ = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_op, w_op_nxt;

  logic        w_cmd_ready_nxt;
  logic [10:0] w_alu_op_nxt;
  logic [3:0]  w_alu_push_nxt;
  logic [15:0] w_bus1_nxt, w_bus2_nxt;
  logic        w_rsp_valid_nxt;
  logic [15:0] w_rsp_data_nxt;
  logic [3:0]  w_rsp_op_nxt;
  logic        w_rsp_err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
    end
  end

  // Next-state logic also computes the next value of every output, which is
  // then registered so no output has a combinational path from an input.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_op_nxt        = r_op;
    w_cmd_ready_nxt = 1'b0;
    w_alu_op_nxt    = '0;
    w_alu_push_nxt  = '0;
    w_bus1_nxt      = '0;
    w_bus2_nxt      = '0;
    w_rsp_valid_nxt = rsp_valid;
    w_rsp_data_nxt  = rsp_data;
    w_rsp_op_nxt    = rsp_op;
    w_rsp_err_nxt   = rsp_err;

    unique case (r_state)
      S_IDLE: begin
        w_cmd_ready_nxt = 1'b1;
        if (cmd_valid && cmd_ready) begin
          w_cmd_ready_nxt = 1'b0;
          w_op_nxt        = cmd_op;
          if (cmd_op <= OP_NOT) begin
            w_state_nxt  = S_EXEC;
            w_alu_op_nxt = 11'(1) << cmd_op;
            w_bus1_nxt   = cmd_a;
            w_bus2_nxt   = cmd_b;
          end else if (cmd_op == OP_DIV || cmd_op == OP_MOD) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_LOAD;
            w_bus1_nxt  = cmd_a;
            w_bus2_nxt  = cmd_b;
          end else begin
            w_state_nxt     = S_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_data_nxt  = '0;
            w_rsp_op_nxt    = cmd_op;
          end
        end
      end
      S_EXEC: begin
        w_state_nxt    = S_READ;
        w_alu_push_nxt = 4'b0001;
        w_bus1_nxt     = bus1;
        w_bus2_nxt     = bus2;
      end
      S_WAIT: begin
        w_bus1_nxt = bus1;
        w_bus2_nxt = bus2;
        if (r_cnt == '0) begin
          w_state_nxt    = S_READ;
          w_alu_push_nxt = (r_op == OP_DIV) ? 4'b0100 : 4'b1000;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_READ: begin
        // Operands stay on the buses so the divider output is still valid.
        w_state_nxt     = S_RESP;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_op_nxt    = r_op;
        w_rsp_data_nxt  = (r_op == OP_DIV || r_op == OP_MOD) ? bus4 : bus3;
      end
      S_RESP: begin
        if (rsp_valid && rsp_ready) begin
          w_state_nxt     = S_IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_cmd_ready_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_rsp_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready <= 1'b0;
      alu_op    <= '0;
      alu_push  <= '0;
      bus1      <= '0;
      bus2      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_op    <= '0;
      rsp_err   <= 1'b0;
    end else begin
      cmd_ready <= w_cmd_ready_nxt;
      alu_op    <= w_alu_op_nxt;
      alu_push  <= w_alu_push_nxt;
      bus1      <= w_bus1_nxt;
      bus2      <= w_bus2_nxt;
      rsp_valid <= w_rsp_valid_nxt;
      rsp_data  <= w_rsp_data_nxt;
      rsp_op    <= w_rsp_op_nxt;
      rsp_err   <= w_rsp_err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_sequencer
// Brief   : Directed self-checking bench for alu_sequencer with a small ALU
//           stand-in driving bus3/bus4.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic [10:0] alu_op;
  logic [3:0]  alu_push;
  logic [15:0] bus1, bus2, bus3, bus4;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_op;
  logic        rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  alu_sequencer #(.DIV_LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_op(alu_op), .alu_push(alu_push),
    .bus1(bus1), .bus2(bus2), .bus3(bus3), .bus4(bus4),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // ALU stand-in: latches a result on the op strobe, shows it on push.
  logic [15:0] r_lo = '0;
  always @(posedge clk) begin
    if (alu_op[0]) r_lo <= bus1 + bus2;
    if (alu_op[1]) r_lo <= bus1 - bus2;
    if (alu_op[2]) r_lo <= bus1 + 16'd1;
    if (alu_op[3]) r_lo <= bus1 - 16'd1;
    if (alu_op[4]) r_lo <= 16'(32'(bus1) * 32'(bus2));
    if (alu_op[9]) r_lo <= bus1 ^ bus2;
  end
  assign bus3 = alu_push[0] ? r_lo : 16'h0;
  assign bus4 = (bus2 == 16'h0) ? 16'h0 :
                alu_push[2] ? bus1 / bus2 :
                alu_push[3] ? bus1 % bus2 : 16'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int          lat, op_first, push_first, stable, viol;
  logic [10:0] op_seen;
  logic [3:0]  push_seen;

  task automatic run_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int guard;
    lat = 0; op_first = 0; push_first = 0; stable = 0; viol = 0;
    op_seen = '0; push_seen = '0;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      op_seen   |= alu_op;
      push_seen |= alu_push;
      if (alu_op != 0 && op_first == 0) op_first = lat;
      if (alu_push != 0 && push_first == 0) push_first = lat;
      if ($countones({alu_op, alu_push}) > 1) viol++;
      if (alu_op == 0 && alu_push == 0 && bus1 == a && bus2 == b) stable++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic expect_rsp(input string tag, input logic [15:0] data, input logic err,
                            input logic [3:0] op, input int exp_lat);
    check({tag, "_lat"},  32'(lat), 32'(exp_lat));
    check({tag, "_data"}, 32'(rsp_data), 32'(data));
    check({tag, "_err"},  32'(rsp_err), 32'(err));
    check({tag, "_op"},   32'(rsp_op), 32'(op));
    check({tag, "_idle_outs"}, {alu_op, alu_push, bus1 | bus2}, 32'h0);
    check({tag, "_onehot"}, 32'(viol), 32'h0);
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_hs_valid"}, 32'(rsp_valid), 32'h0);
    check({tag, "_hs_ready"}, 32'(cmd_ready), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #12;
    check("rst_outs", {cmd_ready, rsp_valid, rsp_err, rsp_op, alu_op, alu_push}, 32'h0);
    check("rst_bus", {bus1, bus2}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_ready_low", 32'(cmd_ready), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("rst_ready_rise", 32'(cmd_ready), 32'h1);

    // ADD
    run_cmd(4'd0, 16'h1234, 16'h0F0F);
    expect_rsp("add", 16'h2143, 1'b0, 4'd0, 3);
    check("add_op_cyc", 32'(op_first), 32'd1);
    check("add_push_cyc", 32'(push_first), 32'd2);
    check("add_masks", {op_seen, push_seen}, {11'h001, 4'b0001});
    handshake("add");

    // Wrap-around / truncation
    run_cmd(4'd1, 16'h0000, 16'h0001);
    expect_rsp("sub", 16'hFFFF, 1'b0, 4'd1, 3);
    check("sub_masks", {op_seen, push_seen}, {11'h002, 4'b0001});
    handshake("sub");
    run_cmd(4'd3, 16'h0000, 16'h0000);
    expect_rsp("dec", 16'hFFFF, 1'b0, 4'd3, 3);
    handshake("dec");
    run_cmd(4'd4, 16'h0100, 16'h0100);
    expect_rsp("mul", 16'h0000, 1'b0, 4'd4, 3);
    check("mul_masks", {op_seen, push_seen}, {11'h010, 4'b0001});
    handshake("mul");
    run_cmd(4'd9, 16'hA5A5, 16'h0FF0);
    expect_rsp("xor", 16'hAA55, 1'b0, 4'd9, 3);
    check("xor_masks", {op_seen, push_seen}, {11'h200, 4'b0001});
    handshake("xor");

    // DIV / MOD
    run_cmd(4'd11, 16'd100, 16'd7);
    expect_rsp("div", 16'd14, 1'b0, 4'd11, 6);
    check("div_stable", 32'(stable), 32'd4);
    check("div_push_cyc", 32'(push_first), 32'd5);
    check("div_masks", {op_seen, push_seen}, {11'h000, 4'b0100});
    handshake("div");
    run_cmd(4'd12, 16'd100, 16'd7);
    expect_rsp("mod", 16'd2, 1'b0, 4'd12, 6);
    check("mod_stable", 32'(stable), 32'd4);
    check("mod_masks", {op_seen, push_seen}, {11'h000, 4'b1000});
    handshake("mod");

    // Backpressure with a competing command held on the input
    run_cmd(4'd0, 16'h0001, 16'h0002);
    expect_rsp("bp", 16'h0003, 1'b0, 4'd0, 3);
    cmd_valid = 1'b1; cmd_op = 4'd1; cmd_a = 16'h5555; cmd_b = 16'h1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", {rsp_valid, rsp_err, rsp_op, rsp_data}, {1'b1, 1'b0, 4'd0, 16'h0003});
      check("bp_cmd_ready", 32'(cmd_ready), 32'h0);
    end
    check("bp_no_strobe", {alu_op, alu_push}, 32'h0);
    handshake("bp");
    cmd_valid = 1'b0;
    @(negedge clk);
    check("bp_not_accepted", {alu_op, alu_push, 1'b0, rsp_valid}, 32'h0);

    // Illegal opcode
    run_cmd(4'd14, 16'hDEAD, 16'hBEEF);
    expect_rsp("ill", 16'h0000, 1'b1, 4'd14, 1);
    handshake("ill");
    check("ill_masks", {op_seen, push_seen}, 32'h0);

    // Reset in the middle of a DIV wait
    while (!cmd_ready) @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'd11; cmd_a = 16'd50; cmd_b = 16'd5;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("mid_wait_bus", {bus1, bus2}, {16'd50, 16'd5});
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", {cmd_ready, rsp_valid, rsp_err, rsp_op, alu_op, alu_push}, 32'h0);
    check("mid_rst_bus", {bus1, bus2}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) check("mid_no_rsp", 32'(rsp_valid), 32'h0);
    end
    check("mid_ready", 32'(cmd_ready), 32'h1);
    run_cmd(4'd0, 16'hFFFF, 16'h0002);
    expect_rsp("post_rst_add", 16'h0001, 1'b0, 4'd0, 3);
    handshake("post_rst_add");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
